bsg_permute_box_stream: RTL and testbench

Registered, flow-controlled successor to the combinational permute box. It reorders `els_p` lanes of `width_p` bits each through a run-time-programmable select vector held in an internal register. Permuted beats pass through a two-entry output buffer. It sits between a ready/valid producer and a valid/yumi consumer and sustains one beat per cycle. A sticky flag reports illegal select vectors: duplicate or out-of-range entries.

---
 rtl/bsg_permute_pkg.sv | 43 ++++
 rtl/bsg_permute_box_stream_two_fifo.sv | 71 +++++++
 rtl/bsg_permute_box_stream.sv | 65 ++++++
 tb/tb_bsg_permute_box_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_permute_pkg.sv
// Shared helpers for the permute box: identity select generation, select
// legality checking, and the output buffer state encoding.
package bsg_permute_pkg;

    localparam int MAX_ELS   = 32;
    localparam int MAX_LG    = 5;
    localparam int MAX_SEL_W = MAX_ELS * MAX_LG;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Select vectors are passed zero-extended to MAX_SEL_W so one function serves any els_p.
    function automatic logic [MAX_SEL_W-1:0] identity_sel(input int els, input int lg);
        logic [MAX_SEL_W-1:0] s;
        s = '0;
        for (int k = 0; k < MAX_ELS; k++)
            if (k < els) s = s | (MAX_SEL_W'(k) << (k * lg));
        return s;
    endfunction

    function automatic logic sel_legal(input logic [MAX_SEL_W-1:0] sel, input int els, input int lg);
        logic [MAX_ELS-1:0]   seen;
        logic [MAX_SEL_W-1:0] mask;
        logic                 ok;
        int                   f;
        seen = '0;
        ok   = 1'b1;
        mask = (MAX_SEL_W'(1) << lg) - MAX_SEL_W'(1);
        for (int k = 0; k < MAX_ELS; k++) begin
            if (k < els) begin
                f = int'((sel >> (k * lg)) & mask);
                if (f >= els) ok = 1'b0;
                else begin
                    if (seen[f[MAX_LG-1:0]]) ok = 1'b0;
                    seen[f[MAX_LG-1:0]] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bsg_permute_box_stream_two_fifo.sv
// Two-entry valid/yumi buffer. All outputs come straight from flops; the
// head register always holds the oldest beat.
module bsg_two_fifo
    import bsg_permute_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [1:0]         r_state;
    logic               r_v;
    logic               r_ready;
    logic [width_p-1:0] r_head;
    logic [width_p-1:0] r_tail;
    logic [1:0]         w_state_n;
    logic               w_accept;

    assign w_accept = v_i & r_ready;
    assign ready_o  = r_ready;
    assign v_o      = r_v;
    assign data_o   = r_head;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_n = ST_ONE;
            ST_ONE: begin
                if (w_accept && !yumi_i)      w_state_n = ST_FULL;
                else if (yumi_i && !w_accept) w_state_n = ST_EMPTY;
            end
            ST_FULL:  if (yumi_i) w_state_n = ST_ONE;
            default:  w_state_n = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_EMPTY;
            r_v     <= 1'b0;
            r_ready <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_n;
            r_v     <= (w_state_n != ST_EMPTY);
            r_ready <= (w_state_n != ST_FULL);
            case (r_state)
                ST_EMPTY: if (w_accept) r_head <= data_i;
                ST_ONE: begin
                    // Simultaneous retire and accept: the new beat becomes the head.
                    if (w_accept && yumi_i) r_head <= data_i;
                    else if (w_accept)      r_tail <= data_i;
                end
                ST_FULL:  if (yumi_i) r_head <= r_tail;
                default: ;
            endcase
        end
    end

    always @(posedge clk_i)
        if (!reset_i && yumi_i) assert (r_v) else $error("yumi_i asserted while v_o is low");

endmodule

// File: rtl/bsg_permute_box_stream.sv
// Streaming lane permuter: beats are reordered through a programmable select
// register as they are accepted, then buffered in a two-entry FIFO.
module bsg_permute_box_stream
    import bsg_permute_pkg::*;
#(
    parameter int width_p   = 8,
    parameter int els_p     = 4,
    parameter int lg_els_lp = $clog2(els_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         cfg_v_i,
    input  logic [els_p*lg_els_lp-1:0]   cfg_sel_i,
    input  logic                         v_i,
    input  logic [els_p*width_p-1:0]     data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [els_p*width_p-1:0]     data_o,
    input  logic                         yumi_i,
    output logic                         sel_err_o
);

    localparam int SEL_W = els_p * lg_els_lp;
    localparam logic [SEL_W-1:0] SEL_ID = SEL_W'(identity_sel(els_p, lg_els_lp));

    logic [SEL_W-1:0]         r_sel;
    logic                     r_err;
    logic                     w_legal;
    logic [els_p*width_p-1:0] w_perm;

    assign w_legal   = sel_legal(MAX_SEL_W'(cfg_sel_i), els_p, lg_els_lp);
    assign sel_err_o = r_err;

    // Illegal selects are still loaded; only the sticky flag records them.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sel <= SEL_ID;
            r_err <= 1'b0;
        end else begin
            if (cfg_v_i)            r_sel <= cfg_sel_i;
            if (cfg_v_i && !w_legal) r_err <= 1'b1;
        end
    end

    // Out-of-range sources match no lane and leave the output lane zero.
    always_comb begin
        w_perm = '0;
        for (int k = 0; k < els_p; k++)
            for (int j = 0; j < els_p; j++)
                if (r_sel[k*lg_els_lp +: lg_els_lp] == lg_els_lp'(j))
                    w_perm[k*width_p +: width_p] = data_i[j*width_p +: width_p];
    end

    bsg_two_fifo #(.width_p(els_p*width_p)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (w_perm),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i)
    );

endmodule

// File: tb/tb_bsg_permute_box_stream.sv
// Bench for bsg_permute_box_stream: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_bsg_permute_box_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_v;
    logic [7:0]  cfg_sel;
    logic        v_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        yumi;
    logic        sel_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q[$];
    logic [7:0]  m_sel;
    logic        m_err;

    always #5 clk = ~clk;

    bsg_permute_box_stream #(.width_p(8), .els_p(4)) dut (
        .clk_i     (clk),
        .reset_i   (rst),
        .cfg_v_i   (cfg_v),
        .cfg_sel_i (cfg_sel),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi),
        .sel_err_o (sel_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] perm(input logic [31:0] d, input logic [7:0] sel);
        logic [31:0] o;
        int s;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            s = (sel >> (2 * k)) & 3;
            o[8*k +: 8] = d[8*s +: 8];
        end
        return o;
    endfunction

    function automatic logic legal(input logic [7:0] sel);
        int cnt[4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int k = 0; k < 4; k++) cnt[(sel >> (2 * k)) & 3]++;
        for (int i = 0; i < 4; i++) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // Called at a negedge: check outputs, drive inputs, step one edge, update model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic y,
                         input logic cv, input logic [7:0] cs);
        logic acc, yy;
        chk("v_o", v_o, q.size() != 0);
        chk("ready_o", ready_o, q.size() < 2);
        chk("sel_err_o", sel_err, m_err);
        if (q.size() != 0) chk("data_o", data_o, q[0]);
        yy      = y && (q.size() != 0);
        acc     = v && (q.size() < 2);
        v_i     = v;
        data_i  = d;
        yumi    = yy;
        cfg_v   = cv;
        cfg_sel = cs;
        @(posedge clk);
        if (yy)  void'(q.pop_front());
        if (acc) q.push_back(perm(d, m_sel));
        if (cv) begin
            if (!legal(cs)) m_err = 1'b1;
            m_sel = cs;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        v_i = 0; data_i = '0; yumi = 0; cfg_v = 0; cfg_sel = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        q.delete();
        m_sel = 8'hE4;
        m_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_v_o", v_o, 1'b0);
        chk("rst_ready_o", ready_o, 1'b0);
        chk("rst_sel_err", sel_err, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Identity pass-through
        cycle(1, 32'h44332211, 0, 0, 8'h00);
        chk("s1_data", data_o, 32'h44332211);
        cycle(0, 0, 1, 0, 8'h00);

        // Reverse
        cycle(0, 0, 0, 1, 8'h1B);
        cycle(1, 32'h44332211, 0, 0, 8'h00);
        chk("s2_data", data_o, 32'h11223344);
        cycle(0, 0, 1, 1, 8'hE4);

        // Config in the same cycle as a beat
        cycle(1, 32'h44332211, 0, 1, 8'h1B);
        cycle(1, 32'hDDCCBBAA, 0, 0, 8'h00);
        chk("s3_first", data_o, 32'h44332211);
        cycle(0, 0, 1, 0, 8'h00);
        chk("s3_second", data_o, 32'hAABBCCDD);
        cycle(0, 0, 1, 1, 8'hE4);

        // Backpressure
        cycle(1, 32'h01010101, 0, 0, 8'h00);
        cycle(1, 32'h02020202, 0, 0, 8'h00);
        chk("s4_full_ready", ready_o, 1'b0);
        cycle(1, 32'h03030303, 0, 0, 8'h00);
        cycle(1, 32'h03030303, 1, 0, 8'h00);
        chk("s4_head2", data_o, 32'h02020202);
        cycle(1, 32'h03030303, 1, 0, 8'h00);
        chk("s4_head3", data_o, 32'h03030303);
        cycle(0, 0, 1, 0, 8'h00);
        chk("s4_empty", v_o, 1'b0);

        // Duplicate select
        cycle(0, 0, 0, 1, 8'h00);
        chk("s5_err_set", sel_err, 1'b1);
        cycle(1, 32'h44332211, 0, 0, 8'h00);
        chk("s5_data", data_o, 32'h11111111);
        cycle(0, 0, 1, 1, 8'hE4);
        cycle(0, 0, 0, 0, 8'h00);
        chk("s5_err_sticky", sel_err, 1'b1);

        // Random traffic; cfg values mix legal permutations and arbitrary bytes
        for (int i = 0; i < 400; i++) begin
            logic [7:0] cs;
            logic [7:0] perms[4];
            perms[0] = 8'hE4; perms[1] = 8'h1B; perms[2] = 8'h4E; perms[3] = 8'h93;
            cs = ($urandom_range(0, 1) == 0) ? perms[$urandom_range(0, 3)] : 8'($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 9) == 0, cs);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 8'h00);

        // Async reset with the buffer full and the error flag set
        cycle(0, 0, 0, 1, 8'h55);
        cycle(1, 32'hCAFEF00D, 0, 0, 8'h00);
        cycle(1, 32'h12345678, 0, 0, 8'h00);
        chk("s6_full", ready_o, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_v_o", v_o, 1'b0);
        chk("s6_async_ready", ready_o, 1'b0);
        chk("s6_async_err", sel_err, 1'b0);
        idle_inputs();
        q.delete();
        m_sel = 8'hE4;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle(1, 32'h44332211, 0, 0, 8'h00);
        chk("s6_identity", data_o, 32'h44332211);
        cycle(0, 0, 1, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
